// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared ADPLL lock-monitor types, thresholds and magnitude helper
// Contents: lock_state_e state encoding, default lock/unlock thresholds used by the
// network top level, and sat_mag() for saturating two's-complement magnitude.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_NO_REF  = 2'd3
    } lock_state_e;

    localparam int DEF_LOCK_THRESH   = 4;
    localparam int DEF_UNLOCK_THRESH = 16;

    // Magnitude of a sign-extended word of 'width' bits, clamped to 2^(width-1)-1 so
    // the most negative code still fits in width-1 unsigned bits.
    function automatic logic [31:0] sat_mag(input logic signed [31:0] value, input int width);
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (width - 1)) - 32'd1;
        mag = (value < 0) ? 32'(-value) : 32'(value);
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

endpackage

// File: rtl/adpll_lock_monitor_if.sv
// rtl/adpll_lock_monitor_if.sv - node-side signal bundle of the ADPLL lock monitor
// master: the ADPLL node / stimulus side (drives enable_i, error_i, sample_i).
// slave : the lock monitor (drives locked_o, lost_o, no_ref_o, state_o, lock_time_o, peak_err_o).
interface adpll_lock_monitor_if #(
    parameter int PDET_WIDTH = 8,
    parameter int TIME_WIDTH = 24
);
    logic                         enable_i;
    logic signed [PDET_WIDTH-1:0] error_i;
    logic                         sample_i;
    logic                         locked_o;
    logic                         lost_o;
    logic                         no_ref_o;
    logic [1:0]                   state_o;
    logic [TIME_WIDTH-1:0]        lock_time_o;
    logic [PDET_WIDTH-2:0]        peak_err_o;

    modport master (
        output enable_i, error_i, sample_i,
        input  locked_o, lost_o, no_ref_o, state_o, lock_time_o, peak_err_o
    );

    modport slave (
        input  enable_i, error_i, sample_i,
        output locked_o, lost_o, no_ref_o, state_o, lock_time_o, peak_err_o
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
// Ports: clk_i, rst_n_i (async active-low), clr_i (wins over inc_i), inc_i, count_o.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/adpll_lock_monitor.sv
// rtl/adpll_lock_monitor.sv - ADPLL lock detector with hysteresis, acquisition timer and ref-loss watchdog
// Ports: fpga_clk_i (fabric clock), rst_pbn_i (async active-low reset),
//        mon_if (slave): enable_i, error_i, sample_i in; locked_o, lost_o, no_ref_o,
//        state_o, lock_time_o, peak_err_o out.
// Optional feature macro: LOCK_MON_PEAK_EN (peak error magnitude tracking while locked).
module adpll_lock_monitor
    import adpll_pkg::*;
#(
    parameter int PDET_WIDTH    = 8,
    parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
    parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4,
    parameter int TIME_WIDTH    = 24,
    parameter int REF_TIMEOUT   = 1024
) (
    input  logic                 fpga_clk_i,
    input  logic                 rst_pbn_i,
    adpll_lock_monitor_if.slave  mon_if
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int GAP_W  = $clog2(REF_TIMEOUT + 1);

    lock_state_e state_q;
    lock_state_e state_d;
    logic        sample_q;
    logic        locked_q;
    logic        lost_q;
    logic        no_ref_q;
    logic        lost_d;

    logic [GOOD_W-1:0]     good_cnt;
    logic [BAD_W-1:0]      bad_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [TIME_WIDTH-1:0] lock_time;

    logic signed [31:0] err_ext;
    logic [31:0]        mag_full;
    logic               strobe;
    logic               good_smp;
    logic               bad_smp;
    logic               timeout;

    // Same clock domain as the node, so a plain rising-edge detect is enough.
    assign strobe   = mon_if.sample_i & ~sample_q;
    assign err_ext  = 32'(mon_if.error_i);
    assign mag_full = sat_mag(err_ext, PDET_WIDTH);
    assign good_smp = (mag_full <= 32'(LOCK_THRESH));
    assign bad_smp  = (mag_full >  32'(UNLOCK_THRESH));
    assign timeout  = (gap_cnt == GAP_W'(REF_TIMEOUT)) &&
                      ((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED));

    always_comb begin
        state_d = state_q;
        if (!mon_if.enable_i) begin
            state_d = ST_IDLE;
        end else if (timeout) begin
            state_d = ST_NO_REF;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ACQUIRE;
                ST_ACQUIRE: if (strobe && good_smp && (good_cnt == GOOD_W'(LOCK_COUNT - 1)))
                                state_d = ST_LOCKED;
                ST_LOCKED:  if (strobe && bad_smp && (bad_cnt == BAD_W'(UNLOCK_COUNT - 1)))
                                state_d = ST_ACQUIRE;
                ST_NO_REF:  if (strobe) state_d = ST_ACQUIRE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    assign lost_d = (state_q == ST_LOCKED) && (state_d == ST_ACQUIRE);

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            state_q  <= ST_IDLE;
            sample_q <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            no_ref_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= mon_if.sample_i;
            locked_q <= (state_d == ST_LOCKED);
            lost_q   <= lost_d;
            no_ref_q <= (state_d == ST_NO_REF);
        end
    end

    // Good run only counts in ACQUIRE; holding it clear elsewhere means every
    // entry into ACQUIRE starts from zero.
    sat_counter #(.WIDTH(GOOD_W)) u_good_cnt (
        .clk_i   (fpga_clk_i),
        .rst_n_i (rst_pbn_i),
        .clr_i   ((state_q != ST_ACQUIRE) | (strobe & ~good_smp)),
        .inc_i   (strobe & good_smp),
        .count_o (good_cnt)
    );

    // Neutral samples (between the thresholds) also break a bad run.
    sat_counter #(.WIDTH(BAD_W)) u_bad_cnt (
        .clk_i   (fpga_clk_i),
        .rst_n_i (rst_pbn_i),
        .clr_i   ((state_q != ST_LOCKED) | (strobe & ~bad_smp)),
        .inc_i   (strobe & bad_smp),
        .count_o (bad_cnt)
    );

    // Held clear while idle so enabling after a long idle period does not trip the watchdog.
    sat_counter #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk_i   (fpga_clk_i),
        .rst_n_i (rst_pbn_i),
        .clr_i   (strobe | (state_q == ST_IDLE)),
        .inc_i   (1'b1),
        .count_o (gap_cnt)
    );

    // Counts only in ACQUIRE, so it freezes on lock and holds through NO_REF;
    // restarts on every fresh acquisition.
    sat_counter #(.WIDTH(TIME_WIDTH)) u_lock_time (
        .clk_i   (fpga_clk_i),
        .rst_n_i (rst_pbn_i),
        .clr_i   ((state_q == ST_IDLE) | ~mon_if.enable_i | lost_d |
                  ((state_q == ST_NO_REF) & (state_d == ST_ACQUIRE))),
        .inc_i   (state_q == ST_ACQUIRE),
        .count_o (lock_time)
    );

    assign mon_if.locked_o    = locked_q;
    assign mon_if.lost_o      = lost_q;
    assign mon_if.no_ref_o    = no_ref_q;
    assign mon_if.state_o     = state_q;
    assign mon_if.lock_time_o = lock_time;

`ifdef LOCK_MON_PEAK_EN
    logic [PDET_WIDTH-2:0] peak_q;
    logic [PDET_WIDTH-2:0] peak_d;
    logic [PDET_WIDTH-2:0] mag;

    assign mag = mag_full[PDET_WIDTH-2:0];

    // Cleared on entry to LOCKED; left alone outside LOCKED so the last peak stays visible.
    always_comb begin
        peak_d = peak_q;
        if ((state_q != ST_LOCKED) && (state_d == ST_LOCKED)) begin
            peak_d = '0;
        end else if ((state_q == ST_LOCKED) && strobe && (mag > peak_q)) begin
            peak_d = mag;
        end
    end

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign mon_if.peak_err_o = peak_q;
`else
    assign mon_if.peak_err_o = '0;
`endif
endmodule

// File: tb/tb_adpll_lock_monitor.sv
// tb/tb_adpll_lock_monitor.sv - directed self-checking bench for adpll_lock_monitor
module tb_adpll_lock_monitor;

`ifdef LOCK_MON_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    adpll_lock_monitor_if #(.PDET_WIDTH(8), .TIME_WIDTH(24)) mon_if ();

    adpll_lock_monitor #(.PDET_WIDTH(8), .TIME_WIDTH(24)) dut (
        .fpga_clk_i (clk),
        .rst_pbn_i  (rst_n),
        .mon_if     (mon_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle high on sample_i carrying error e; returns at the next negedge.
    task automatic pulse(input logic signed [7:0] e);
        mon_if.sample_i = 1'b1;
        mon_if.error_i  = e;
        @(negedge clk);
        mon_if.sample_i = 1'b0;
    endtask

    // Strobe period of 32 cycles.
    task automatic strobe(input logic signed [7:0] e);
        pulse(e);
        wait_cycles(31);
    endtask

    initial begin
        rst_n           = 1'b0;
        mon_if.enable_i = 1'b0;
        mon_if.sample_i = 1'b0;
        mon_if.error_i  = '0;
        wait_cycles(3);
        check("rst_state",     32'(mon_if.state_o),     32'd0);
        check("rst_locked",    32'(mon_if.locked_o),    32'd0);
        check("rst_lost",      32'(mon_if.lost_o),      32'd0);
        check("rst_no_ref",    32'(mon_if.no_ref_o),    32'd0);
        check("rst_lock_time", 32'(mon_if.lock_time_o), 32'd0);
        check("rst_peak",      32'(mon_if.peak_err_o),  32'd0);

        rst_n = 1'b1;
        wait_cycles(2);
        check("idle_hold", 32'(mon_if.state_o), 32'd0);

        // Acquire: 16 strobes at error 2, first strobe one cycle after enable.
        mon_if.enable_i = 1'b1;
        wait_cycles(1);
        check("acq_entry", 32'(mon_if.state_o), 32'd1);
        repeat (15) strobe(8'sd2);
        check("pre_lock", 32'(mon_if.locked_o), 32'd0);
        pulse(8'sd2);
        check("lock_flag",  32'(mon_if.locked_o),    32'd1);
        check("lock_state", 32'(mon_if.state_o),     32'd2);
        check("lock_time",  32'(mon_if.lock_time_o), 32'd481);
        wait_cycles(31);
        check("lock_time_frozen", 32'(mon_if.lock_time_o), 32'd481);

        // Hysteresis: neutral errors keep lock, a neutral strobe breaks a bad run.
        repeat (5) strobe(8'sd10);
        check("neutral_locked", 32'(mon_if.locked_o), 32'd1);
        repeat (3) strobe(-8'sd20);
        strobe(8'sd10);
        check("bad_run_reset", 32'(mon_if.locked_o), 32'd1);
        repeat (3) strobe(-8'sd20);
        check("three_bad_locked", 32'(mon_if.locked_o), 32'd1);
        pulse(-8'sd20);
        check("lost_pulse",      32'(mon_if.lost_o),      32'd1);
        check("lost_state",      32'(mon_if.state_o),     32'd1);
        check("lost_locked",     32'(mon_if.locked_o),    32'd0);
        check("lost_time_reset", 32'(mon_if.lock_time_o), 32'd0);
        check("peak_20",         32'(mon_if.peak_err_o),  PEAK_EN ? 32'd20 : 32'd0);
        wait_cycles(1);
        check("lost_one_cycle", 32'(mon_if.lost_o),      32'd0);
        check("time_restart",   32'(mon_if.lock_time_o), 32'd1);
        wait_cycles(30);

        // Acquire restart: a -5 strobe breaks the good run; |4| is still good.
        repeat (8) strobe(8'sd2);
        strobe(8'sd4);
        strobe(-8'sd4);
        strobe(-8'sd5);
        repeat (15) strobe(8'sd0);
        check("restart_not_locked", 32'(mon_if.locked_o), 32'd0);
        check("restart_state",      32'(mon_if.state_o),  32'd1);
        pulse(8'sd0);
        check("restart_locked", 32'(mon_if.locked_o), 32'd1);
        wait_cycles(31);

        // Saturation: 8'h80 reads as magnitude 127 and counts as bad.
        repeat (3) strobe(8'sh80);
        check("sat_still_locked", 32'(mon_if.locked_o),   32'd1);
        check("sat_peak",         32'(mon_if.peak_err_o), PEAK_EN ? 32'd127 : 32'd0);
        pulse(8'sh80);
        check("sat_lost",      32'(mon_if.lost_o),     32'd1);
        check("sat_peak_hold", 32'(mon_if.peak_err_o), PEAK_EN ? 32'd127 : 32'd0);

        // No reference: last strobe was cycle S, we are in S+1.
        wait_cycles(1023);
        check("gap_1023_state",  32'(mon_if.state_o),  32'd1);
        check("gap_1023_no_ref", 32'(mon_if.no_ref_o), 32'd0);
        wait_cycles(1);
        check("gap_1024_no_ref", 32'(mon_if.no_ref_o), 32'd0);
        wait_cycles(1);
        check("no_ref_flag",  32'(mon_if.no_ref_o), 32'd1);
        check("no_ref_state", 32'(mon_if.state_o),  32'd3);
        pulse(8'sd0);
        check("ref_back_state",  32'(mon_if.state_o),     32'd1);
        check("ref_back_no_ref", 32'(mon_if.no_ref_o),    32'd0);
        check("ref_back_time",   32'(mon_if.lock_time_o), 32'd0);
        wait_cycles(31);

        // Disable while locked.
        repeat (15) strobe(8'sd0);
        pulse(8'sd0);
        check("relock", 32'(mon_if.locked_o), 32'd1);
        wait_cycles(5);
        mon_if.enable_i = 1'b0;
        wait_cycles(1);
        check("disable_state",  32'(mon_if.state_o),  32'd0);
        check("disable_locked", 32'(mon_if.locked_o), 32'd0);
        check("disable_lost",   32'(mon_if.lost_o),   32'd0);

        // Asynchronous reset mid-acquire, applied between clock edges.
        mon_if.enable_i = 1'b1;
        wait_cycles(1);
        repeat (3) strobe(8'sd2);
        check("pre_rst_state", 32'(mon_if.state_o),     32'd1);
        check("pre_rst_time",  32'(mon_if.lock_time_o), 32'd96);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(mon_if.state_o),     32'd0);
        check("async_rst_time",  32'(mon_if.lock_time_o), 32'd0);
        check("async_rst_lock",  32'(mon_if.locked_o),    32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/adpll_lock_monitor.md
# adpll_lock_monitor

Per-node lock detector that sits directly downstream of a network ADPLL node. It consumes the node's signed phase-detector error word and divided generated clock, both in the 258 MHz fabric domain. It decides acquire, locked or lost with hysteresis and measures acquisition time in fabric cycles. Its outputs drive board LEDs, the 7-segment display path and test headers.

## Interface
Parameters:
- PDET_WIDTH, 8: width of the two's-complement error word
- LOCK_THRESH, 4: magnitude at or below which a sample counts as good
- UNLOCK_THRESH, 16: magnitude above which a sample counts as bad while locked; must be ≥ LOCK_THRESH
- LOCK_COUNT, 16: consecutive good samples required to declare lock
- UNLOCK_COUNT, 4: consecutive bad samples required to declare loss
- TIME_WIDTH, 24: width of the acquisition-time counter
- REF_TIMEOUT, 1024: fabric cycles without a sample edge before the reference is declared missing

Ports:
- fpga_clk_i  in  1  fabric clock (258 MHz)
- rst_pbn_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  monitor enable, synchronous to fpga_clk_i
- error_i  in  PDET_WIDTH  signed phase error from the ADPLL node
- sample_i  in  1  node's gen_div8 output; each rising edge marks one sample
- locked_o  out  1  lock flag
- lost_o  out  1  one-cycle pulse on the LOCKED→ACQUIRE transition
- no_ref_o  out  1  high in NO_REF state
- state_o  out  2  encoded state
- lock_time_o  out  TIME_WIDTH  cycles from acquisition start to lock, saturating
- peak_err_o  out  PDET_WIDTH-1  peak error magnitude while locked

## Operation
- Edge detect: sample_q is registered from sample_i. The strobe is sample_i & ~sample_q. No synchroniser is used, because the input shares the clock domain.
- Magnitude: |error_i| is taken as an unsigned PDET_WIDTH-1 value. The most negative code, -2^(PDET_WIDTH-1), saturates to 2^(PDET_WIDTH-1)-1.
- States (state_o encoding): IDLE=0, ACQUIRE=1, LOCKED=2, NO_REF=3.
- IDLE: entered when enable_i is low, from any state. On enable_i high, go to ACQUIRE, clear good_cnt and bad_cnt, and clear lock_time_o.
- ACQUIRE:
  - lock_time_o increments every cycle and saturates at all-ones.
  - On a strobe with magnitude ≤ LOCK_THRESH, good_cnt increments; otherwise good_cnt clears.
  - A strobe that makes good_cnt reach LOCK_COUNT moves the block to LOCKED. lock_time_o is then frozen.
- LOCKED:
  - On a strobe with magnitude > UNLOCK_THRESH, bad_cnt increments.
  - On any other strobe, bad_cnt clears. Magnitudes between the two thresholds are neutral for this purpose.
  - When bad_cnt reaches UNLOCK_COUNT, go to ACQUIRE, pulse lost_o, clear good_cnt, and restart lock_time_o from 0.
- Timeout: a gap counter clears on every strobe and increments otherwise. If it reaches REF_TIMEOUT in ACQUIRE or LOCKED, go to NO_REF. A strobe in NO_REF goes to ACQUIRE with counters cleared.
- Priority, highest first: enable_i low, then timeout, then strobe evaluation.
- locked_o is 1 exactly when the state is LOCKED.

## Timing
- Reset values:
  - state IDLE
  - locked_o, lost_o and no_ref_o all 0
  - lock_time_o 0 and peak_err_o 0
  - all internal counters 0
- Cycle numbering: cycle N is the first cycle with sample_i high after a low cycle, so the strobe is combinational in cycle N.
- Sampling: error_i is sampled in cycle N. State and outputs update at the clock edge ending cycle N.
- Latency: locked_o is visible in cycle N+1 after the LOCK_COUNT-th good strobe. lost_o is high only in cycle N+1.
- Timeout: no_ref_o rises one cycle after the gap counter reaches REF_TIMEOUT.
- Reset mid-operation: asynchronous return to the reset values, regardless of state.

## Configuration
- Macro LOCK_MON_PEAK_EN.
- Defined: in LOCKED, peak_err_o takes the maximum sampled magnitude. It clears on entry to LOCKED, and its value holds after lock is lost.
- Undefined: peak_err_o is tied to 0 and no peak register is synthesised.

## Structure
- Shared package adpll_pkg holds:
  - the state enum encoding (IDLE, ACQUIRE, LOCKED, NO_REF)
  - a saturating-magnitude function
  - the default LOCK_THRESH and UNLOCK_THRESH constants, shared with the network top level
- One sub-module, sat_counter (parameterised width, increment, clear, saturate). It is used for lock_time, good_cnt, bad_cnt and the gap counter.

## Test plan
All scenarios use defaults, with a strobe every 32 cycles unless stated.
- Reset and enable: reset, then enable_i=1 and error_i=2 on every strobe. Expect locked_o=1 one cycle after the 16th strobe. lock_time_o equals the cycle count from enable to that strobe.
- Acquire restart: 10 strobes at error_i=2, one at -5, then 16 at 0. Lock occurs only after the last 16.
- Hysteresis: while locked, send error_i=10 (neutral) indefinitely; stay locked. Then send 4 strobes at -20: lost_o pulses for one cycle, state becomes 1 and lock_time_o restarts.
- Saturation: while locked, send error_i=8'h80. Magnitude is 127 and counts as bad; with LOCK_MON_PEAK_EN, peak_err_o=127.
- No reference: stop sample_i for 1024 cycles. Expect no_ref_o=1 and state 3. One strobe returns to ACQUIRE.
- Disable and reset: drop enable_i while locked, and separately assert rst_pbn_i mid-acquire. Expect the IDLE or reset values on the next cycle and asynchronously, respectively.
